// File: rtl/adder_sequencer.sv
// adder_sequencer: initiator side of the 4-bit adder interface.
// Accepts operand pairs on a ready/valid command stream and issues them to an
// adder. After a fixed latency it captures the adder result and checks it
// against a locally computed sum. Checked results are queued in a show-ahead
// response FIFO. A credit scheme (FIFO occupancy plus ops in flight) keeps the
// FIFO from ever overflowing.
module adder_sequencer #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_valid,
    input  logic [6:0] add_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [6:0] rsp_c,
    output logic       rsp_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

    // Reference sum of two 4-bit operands, zero-extended to the 7-bit result
    function automatic logic [6:0] ref_sum(input logic [3:0] a, input logic [3:0] b);
        return {3'b000, a} + {3'b000, b};
    endfunction

    // Handshake / credit signals
    logic          accept_s;
    logic          capture_s;
    logic          pop_s;
    logic [OW-1:0] occupied_s;

    // Issue register
    logic [3:0] add_a_q, add_a_d;
    logic [3:0] add_b_q, add_b_d;
    logic       add_valid_q, add_valid_d;
    logic [6:0] exp_q, exp_d;

    // Expected-sum pipeline, stage 0 trails add_valid by one cycle
    logic       pipe_vld_q [LATENCY];
    logic       pipe_vld_d [LATENCY];
    logic [6:0] pipe_exp_q [LATENCY];
    logic [6:0] pipe_exp_d [LATENCY];

    // Captured entry: {err, c}
    logic       cap_err_s;
    logic [7:0] cap_entry_s;

    // Response FIFO
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_s;

    // Operation and error bookkeeping
    logic [CW-1:0] inflight_q, inflight_d;
    logic [7:0]    err_count_q, err_count_d;

    // Credits and handshakes: the sum of FIFO entries and ops in flight never exceeds DEPTH
    always_comb begin
        occupied_s = OW'(count_q) + OW'(inflight_q);
        cmd_ready  = !reset && (occupied_s < DEPTH_O);
        accept_s   = cmd_valid && cmd_ready;
        capture_s  = pipe_vld_q[LATENCY-1];
        pop_s      = (count_q != CW'(0)) && rsp_ready;
    end

    // Issue register next state: load on accept, otherwise drop valid and hold operands
    always_comb begin
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        exp_d       = exp_q;
        add_valid_d = 1'b0;
        if (accept_s) begin
            add_a_d     = cmd_a;
            add_b_d     = cmd_b;
            exp_d       = ref_sum(cmd_a, cmd_b);
            add_valid_d = 1'b1;
        end else begin
            add_valid_d = 1'b0;
        end
    end

    // Expected-sum shift register, tail lines up with the adder's result cycle
    always_comb begin
        pipe_vld_d[0] = add_valid_q;
        pipe_exp_d[0] = exp_q;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_exp_d[i] = pipe_exp_q[i-1];
        end
    end

    // Capture: compare returned result with the expected sum carried down the pipeline
    always_comb begin
        cap_err_s   = (add_c != pipe_exp_q[LATENCY-1]);
        cap_entry_s = {cap_err_s, add_c};
    end

    // FIFO next state: write on capture, advance read pointer on pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (capture_s) begin
            mem_d[wr_ptr_q] = cap_entry_s;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({capture_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // In-flight and saturating error counters
    always_comb begin
        case ({accept_s, capture_s})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        if (capture_s && cap_err_s && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Output drive: head of FIFO shown ahead, zeroed when empty
    always_comb begin
        head_s    = mem_q[rd_ptr_q];
        rsp_valid = (count_q != CW'(0));
        if (rsp_valid) begin
            rsp_c   = head_s[6:0];
            rsp_err = head_s[7];
        end else begin
            rsp_c   = 7'd0;
            rsp_err = 1'b0;
        end
        add_a     = add_a_q;
        add_b     = add_b_q;
        add_valid = add_valid_q;
        err_count = err_count_q;
        busy      = (inflight_q != CW'(0)) || rsp_valid || add_valid_q;
    end

    // Issue register state
    always_ff @(posedge clk) begin
        if (reset) begin
            add_a_q     <= 4'd0;
            add_b_q     <= 4'd0;
            add_valid_q <= 1'b0;
            exp_q       <= 7'd0;
        end else begin
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_valid_q <= add_valid_d;
            exp_q       <= exp_d;
        end
    end

    // Expected-sum pipeline state; reset flushes it so late adder results are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_exp_q[i] <= 7'd0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_d[i];
                pipe_exp_q[i] <= pipe_exp_d[i];
            end
        end
    end

    // Response FIFO state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q  <= '0;
            err_count_q <= 8'd0;
        end else begin
            inflight_q  <= inflight_d;
            err_count_q <= err_count_d;
        end
    end

    adder_sequencer_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk_i       (clk),
        .reset_i     (reset),
        .count_i     (count_q),
        .inflight_i  (inflight_q),
        .capture_i   (capture_s),
        .pop_i       (pop_s),
        .add_valid_i (add_valid_q)
    );

endmodule

// adder_sequencer_chk: invariants of the credit scheme and response FIFO.
module adder_sequencer_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk_i,
    input logic          reset_i,
    input logic [CW-1:0] count_i,
    input logic [CW-1:0] inflight_i,
    input logic          capture_i,
    input logic          pop_i,
    input logic          add_valid_i
);

    // Check occupancy bound, overflow freedom and issue tracking every cycle
    always @(posedge clk_i) begin
        if (!reset_i) begin
            a_credit: assert ((int'(count_i) + int'(inflight_i)) <= DEPTH);
            a_no_overflow: assert (!(capture_i && !pop_i && (int'(count_i) == DEPTH)));
            a_issue_tracked: assert (!add_valid_i || (inflight_i != '0));
        end
    end

endmodule

// File: tb/tb_adder_sequencer.sv
// Testbench for adder_sequencer: one instance at LATENCY=1 and one at LATENCY=3,
// each driven by a behavioural adder model, checked against a queue scoreboard.
module tb_adder_sequencer;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;   // 0 ideal adder, 1 always +1, 2 +1 when a is odd
    int err_total = 0;  // faulty results issued since last reset

    typedef struct {
        logic [6:0] c;
        logic       err;
    } exp_t;
    exp_t sb[$];

    logic       reset;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b, add_a, add_b;
    logic       add_valid;
    logic [6:0] add_c;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic [6:0] rsp_c;
    logic [7:0] err_count;

    logic       l3_cmd_valid, l3_cmd_ready;
    logic [3:0] l3_cmd_a, l3_cmd_b, l3_add_a, l3_add_b;
    logic       l3_add_valid;
    logic [6:0] l3_add_c;
    logic       l3_rsp_valid, l3_rsp_ready, l3_rsp_err, l3_busy;
    logic [6:0] l3_rsp_c;
    logic [7:0] l3_err_count;

    adder_sequencer #(.LATENCY(1), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .add_a(add_a), .add_b(add_b),
        .add_valid(add_valid), .add_c(add_c), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_err(rsp_err),
        .err_count(err_count), .busy(busy)
    );

    adder_sequencer #(.LATENCY(3), .DEPTH(DEPTH)) dut3 (
        .clk(clk), .reset(reset), .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready),
        .cmd_a(l3_cmd_a), .cmd_b(l3_cmd_b), .add_a(l3_add_a), .add_b(l3_add_b),
        .add_valid(l3_add_valid), .add_c(l3_add_c), .rsp_valid(l3_rsp_valid),
        .rsp_ready(l3_rsp_ready), .rsp_c(l3_rsp_c), .rsp_err(l3_rsp_err),
        .err_count(l3_err_count), .busy(l3_busy)
    );

    function automatic logic [6:0] adder_fn(input logic [3:0] a, input logic [3:0] b, input int m);
        int s;
        s = int'(a) + int'(b);
        if (m == 1) s = s + 1;
        if (m == 2 && a[0]) s = s + 1;
        return 7'(s);
    endfunction

    // Adder models: result registered LATENCY cycles after the operands
    logic [6:0] c1_q;
    logic [6:0] c3_q [3];
    always @(posedge clk) begin
        c1_q    <= adder_fn(add_a, add_b, mode);
        c3_q[0] <= adder_fn(l3_add_a, l3_add_b, 0);
        c3_q[1] <= c3_q[0];
        c3_q[2] <= c3_q[1];
    end
    assign add_c    = c1_q;
    assign l3_add_c = c3_q[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd1; rsp_ready = 1'b0;
        tick();
        tick();
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready: got %0b expected 0", cmd_ready); end
        checks++; if ({add_a, add_b, add_valid} !== 9'd0) begin failures++; $display("FAIL reset_issue: got %0h expected 0", {add_a, add_b, add_valid}); end
        checks++; if ({rsp_valid, rsp_c, rsp_err} !== 9'd0) begin failures++; $display("FAIL reset_rsp: got %0h expected 0", {rsp_valid, rsp_c, rsp_err}); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if ({l3_rsp_valid, l3_add_valid, l3_busy} !== 3'd0) begin failures++; $display("FAIL reset_l3: got %0h expected 0", {l3_rsp_valid, l3_add_valid, l3_busy}); end
        cmd_valid = 1'b0; reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %0b expected 1", cmd_ready); end
        sb.delete(); err_total = 0;
    endtask

    task automatic test_single();
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_a = 4'd3; cmd_b = 4'd4;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %0b expected 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        checks++; if ({add_valid, add_a, add_b} !== {1'b1, 4'd3, 4'd4}) begin failures++; $display("FAIL single_issue: got %0h expected %0h", {add_valid, add_a, add_b}, {1'b1, 4'd3, 4'd4}); end
        tick();
        checks++; if ({add_valid, add_a, add_b} !== {1'b0, 4'd3, 4'd4}) begin failures++; $display("FAIL single_hold: got %0h expected %0h", {add_valid, add_a, add_b}, {1'b0, 4'd3, 4'd4}); end
        checks++; if ({rsp_valid, busy} !== 2'b01) begin failures++; $display("FAIL single_early: got %0b expected 01", {rsp_valid, busy}); end
        tick();
        checks++; if ({rsp_valid, rsp_c, rsp_err} !== {1'b1, 7'd7, 1'b0}) begin failures++; $display("FAIL single_rsp: got %0h expected %0h", {rsp_valid, rsp_c, rsp_err}, {1'b1, 7'd7, 1'b0}); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL single_err_count: got %0d expected 0", err_count); end
        tick();
        checks++; if ({rsp_valid, rsp_c} !== {1'b1, 7'd7}) begin failures++; $display("FAIL single_stall_hold: got %0h expected %0h", {rsp_valid, rsp_c}, {1'b1, 7'd7}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin failures++; $display("FAIL single_drain: got %0b expected 00", {rsp_valid, busy}); end
    endtask

    task automatic test_stream_backpressure();
        int acc = 0;
        int nrsp = 0;
        bit hs_c, hs_r;
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            cmd_valid = (acc < 6); cmd_a = acc[3:0]; cmd_b = 4'(15 - acc);
            hs_c = cmd_valid && cmd_ready;
            tick();
            if (hs_c) acc++;
        end
        checks++; if (acc != 4) begin failures++; $display("FAIL stream_accepted: got %0d expected 4", acc); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL stream_full_ready: got %0b expected 0", cmd_ready); end
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            cmd_valid = (acc < 6); cmd_a = acc[3:0]; cmd_b = 4'(15 - acc);
            hs_c = cmd_valid && cmd_ready;
            hs_r = rsp_valid && rsp_ready;
            if (hs_r) begin
                nrsp++;
                checks++; if (rsp_c !== 7'd15) begin failures++; $display("FAIL stream_rsp_c: got %0d expected 15", rsp_c); end
            end
            tick();
            if (hs_c) acc++;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        checks++; if (acc != 6 || nrsp != 6) begin failures++; $display("FAIL stream_totals: got acc=%0d rsp=%0d expected 6/6", acc, nrsp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_idle: got %0b expected 0", busy); end
    endtask

    // Randomised traffic against the queue scoreboard; outstanding ops = queue size
    task automatic run_stream(input int n_ops, input int pv, input int pr, input bit full_rate);
        int acc = 0;
        int cyc = 0;
        int sat;
        exp_t e;
        while ((acc < n_ops || sb.size() > 0) && cyc < 4000) begin
            cmd_valid = (acc < n_ops) && ($urandom_range(99) < pv);
            cmd_a = 4'($urandom_range(15)); cmd_b = 4'($urandom_range(15));
            rsp_ready = ($urandom_range(99) < pr);
            checks++; if (cmd_ready !== (sb.size() < DEPTH)) begin failures++; $display("FAIL credit_ready: got %0b expected %0b", cmd_ready, sb.size() < DEPTH); end
            checks++; if (busy !== (sb.size() > 0)) begin failures++; $display("FAIL busy_model: got %0b expected %0b", busy, sb.size() > 0); end
            if (full_rate && acc < n_ops) begin
                checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL full_rate_ready: got %0b expected 1", cmd_ready); end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++; $display("FAIL rsp_unexpected: got c=%0d expected none", rsp_c);
                end else begin
                    e = sb.pop_front();
                    checks++; if ({rsp_c, rsp_err} !== {e.c, e.err}) begin failures++; $display("FAIL rsp_data: got c=%0d err=%0b expected c=%0d err=%0b", rsp_c, rsp_err, e.c, e.err); end
                end
            end
            if (cmd_valid && cmd_ready) begin
                e.c = adder_fn(cmd_a, cmd_b, mode);
                e.err = (int'(e.c) != int'(cmd_a) + int'(cmd_b));
                if (e.err) err_total++;
                sb.push_back(e);
                acc++;
            end
            tick();
            cyc++;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        checks++; if (acc != n_ops || sb.size() != 0) begin failures++; $display("FAIL stream_timeout: got acc=%0d pending=%0d expected %0d/0", acc, sb.size(), n_ops); end
        sat = (err_total > 255) ? 255 : err_total;
        checks++; if (int'(err_count) != sat) begin failures++; $display("FAIL err_count_model: got %0d expected %0d", err_count, sat); end
    endtask

    task automatic test_faulty();
        mode = 1; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_a = 4'd15; cmd_b = 4'd15;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++; if ({rsp_valid, rsp_c, rsp_err} !== {1'b1, 7'd31, 1'b1}) begin failures++; $display("FAIL fault_rsp: got %0h expected %0h", {rsp_valid, rsp_c, rsp_err}, {1'b1, 7'd31, 1'b1}); end
        checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL fault_err_count: got %0d expected 1", err_count); end
        err_total = 1;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        run_stream(300, 100, 100, 1'b1);
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL fault_saturate: got %0d expected 255", err_count); end
        mode = 0;
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_a = 4'(i + 1); cmd_b = 4'(i + 2);
            checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %0b expected 1", cmd_ready); end
            tick();
        end
        cmd_valid = 1'b0;
        checks++; if ({rsp_valid, busy, cmd_ready} !== 3'b110) begin failures++; $display("FAIL mid_loaded: got %0b expected 110", {rsp_valid, busy, cmd_ready}); end
        reset = 1'b1;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready: got %0b expected 0", cmd_ready); end
        tick();
        reset = 1'b0;
        sb.delete(); err_total = 0;
        checks++; if ({rsp_valid, busy, add_valid} !== 3'b000) begin failures++; $display("FAIL mid_flush: got %0b expected 000", {rsp_valid, busy, add_valid}); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL mid_err_clear: got %0d expected 0", err_count); end
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid || busy) seen++;
            tick();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL mid_stale_capture: got %0d expected 0", seen); end
        cmd_valid = 1'b1; cmd_a = 4'd8; cmd_b = 4'd8;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++; if ({rsp_valid, rsp_c, rsp_err} !== {1'b1, 7'd16, 1'b0}) begin failures++; $display("FAIL mid_first_op: got %0h expected %0h", {rsp_valid, rsp_c, rsp_err}, {1'b1, 7'd16, 1'b0}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_latency3();
        int ta [4] = '{1, 2, 9, 6};
        int tb [4] = '{1, 5, 0, 6};
        int exp_tail [3] = '{9, 12, 10};
        int got = 0;
        l3_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            l3_cmd_valid = 1'b1; l3_cmd_a = 4'(ta[i]); l3_cmd_b = 4'(tb[i]);
            checks++; if (l3_cmd_ready !== 1'b1) begin failures++; $display("FAIL l3_ready: got %0b expected 1", l3_cmd_ready); end
            tick();
            checks++; if ({l3_add_valid, l3_add_a, l3_add_b} !== {1'b1, 4'(ta[i]), 4'(tb[i])}) begin failures++; $display("FAIL l3_issue: got %0h expected %0h", {l3_add_valid, l3_add_a, l3_add_b}, {1'b1, 4'(ta[i]), 4'(tb[i])}); end
        end
        l3_cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if ({l3_cmd_ready, l3_rsp_valid, l3_rsp_c} !== {1'b0, 1'b1, 7'd2}) begin failures++; $display("FAIL l3_full_head: got %0h expected %0h", {l3_cmd_ready, l3_rsp_valid, l3_rsp_c}, {1'b0, 1'b1, 7'd2}); end
        l3_rsp_ready = 1'b1;
        tick();
        l3_rsp_ready = 1'b0;
        l3_cmd_valid = 1'b1; l3_cmd_a = 4'd7; l3_cmd_b = 4'd3;
        checks++; if ({l3_cmd_ready, l3_rsp_c} !== {1'b1, 7'd7}) begin failures++; $display("FAIL l3_credit_back: got %0h expected %0h", {l3_cmd_ready, l3_rsp_c}, {1'b1, 7'd7}); end
        tick();
        l3_cmd_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if ({l3_cmd_ready, l3_rsp_c} !== {1'b0, 7'd7}) begin failures++; $display("FAIL l3_before_pushpop: got %0h expected %0h", {l3_cmd_ready, l3_rsp_c}, {1'b0, 7'd7}); end
        l3_rsp_ready = 1'b1;
        tick();
        checks++; if ({l3_rsp_valid, l3_rsp_c, l3_cmd_ready} !== {1'b1, 7'd9, 1'b1}) begin failures++; $display("FAIL l3_pushpop: got %0h expected %0h", {l3_rsp_valid, l3_rsp_c, l3_cmd_ready}, {1'b1, 7'd9, 1'b1}); end
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            if (l3_rsp_valid) begin
                checks++; if ({l3_rsp_c, l3_rsp_err} !== {7'(exp_tail[got]), 1'b0}) begin failures++; $display("FAIL l3_order: got %0d expected %0d", l3_rsp_c, exp_tail[got]); end
                got++;
            end
            tick();
        end
        l3_rsp_ready = 1'b0;
        checks++; if (got != 3 || l3_busy !== 1'b0) begin failures++; $display("FAIL l3_drain: got %0d busy=%0b expected 3 busy=0", got, l3_busy); end
    endtask

    task automatic test_back_to_back();
        mode = 0;
        run_stream(20, 100, 100, 1'b1);
    endtask

    task automatic test_random();
        mode = 2;
        run_stream(200, 70, 50, 1'b0);
        mode = 0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; rsp_ready = 1'b0;
        l3_cmd_valid = 1'b0; l3_cmd_a = 4'd0; l3_cmd_b = 4'd0; l3_rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_stream_backpressure();
        test_faulty();
        test_reset_midflight();
        test_latency3();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
